fifo_sync_param: RTL and testbench

- Parametrised single-clock synchronous FIFO. Replaces the fixed 8-bit × 4-entry FIFO used between the UART RX/TX paths and the sensor/control logic.
- Adds generic width and depth, an occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Data output is show-ahead: the head word is visible before it is popped.

---
 rtl/fifo_sync_param.sv | 130 +++++++++++++
 tb/tb_fifo_sync_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock show-ahead FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a synchronous flush. The count register is the only source of
// truth for fullness; pointer equality is never consulted.
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  // Storage deliberately has no reset; only the pointers and count are cleared.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic full_s, empty_s;
  logic push_ok, pop_ok;
  logic mem_we;

  // Status flags decoded purely from the count register (no push/pop path).
  always_comb begin
    full_s       = (count_q == DEPTH_C);
    empty_s      = (count_q == '0);
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
  end

  // Accept decisions use registered state only, so a push into a full queue
  // is dropped even if a pop drains one entry at the same edge.
  always_comb begin
    push_ok = push & ~full_s;
    pop_ok  = pop & ~empty_s;
  end

  // Next-state for pointers, count and sticky flags; rst > flush > push/pop.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;

    if (rst) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (flush) begin
      // Flush discards contents but leaves the error history intact.
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + 1'b1;
      end

      if (push_ok && !pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - 1'b1;
      end

      // A new error in the same cycle as clr_err wins over the clear.
      overflow_d  = (overflow_q  & ~clr_err) | (push & full_s);
      underflow_d = (underflow_q & ~clr_err) | (pop & empty_s);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    wptr_q      <= wptr_d;
    rptr_q      <= rptr_d;
    count_q     <= count_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // Storage write port; the word becomes visible at the head one clock later.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  // Show-ahead read: head word straight from storage via the read pointer.
  always_comb begin
    pop_data  = mem_q[rptr_q];
    count     = count_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a directed vector table for the main scenarios,
// a hand-written corner sequence, then random traffic against a queue model.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst, flush, push, pop, clr_err;
  logic [DW-1:0] push_data;
  logic [DW-1:0] pop_data;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected status outputs come from the expected count by the flag definitions.
  task automatic check_state(input string tag, input int cnt, input bit ovf, input bit unf,
                             input bit chk, input logic [7:0] dout);
    check({tag, " count"}, 32'(count), 32'(cnt));
    check({tag, " empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, " full"}, 32'(full), 32'(cnt == DEPTH));
    check({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= AF));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
    check({tag, " overflow"}, 32'(overflow), 32'(ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(unf));
    if (chk) check({tag, " pop_data"}, 32'(pop_data), 32'(dout));
  endtask

  // Apply inputs away from the edge, clock once, sample 1 ns after the edge.
  task automatic drive(input logic r, input logic f, input logic pu, input logic po,
                       input logic c, input logic [7:0] d);
    rst = r; flush = f; push = pu; pop = po; clr_err = c; push_data = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, flush, push, pop, clr;
    logic [7:0] din;
    int         cnt;
    bit         ovf, unf, chk;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic f, input logic pu, input logic po,
                              input logic c, input logic [7:0] d, input int cnt,
                              input bit ovf, input bit unf, input bit chk,
                              input logic [7:0] dout);
    vec_t v;
    v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.clr = c; v.din = d;
    v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.chk = chk; v.dout = dout;
    vecs.push_back(v);
  endfunction

  // Reference model: a plain queue plus two sticky bits.
  logic [7:0] mq[$];
  bit m_ovf, m_unf;

  task automatic model_step(input logic r, input logic f, input logic pu, input logic po,
                            input logic c, input logic [7:0] d);
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (r) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else if (f) begin
      mq.delete();
    end else begin
      if (po && !was_empty) void'(mq.pop_front());
      if (pu && !was_full) mq.push_back(d);
      m_ovf = (m_ovf && !c) || (pu && was_full);
      m_unf = (m_unf && !c) || (po && was_empty);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;

    //     rst flush push pop clr din    cnt ovf unf chk dout
    add(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    // Fill with four words; head shows the first word from the next cycle.
    add(0, 0, 1, 0, 0, 8'hA1, 1, 0, 0, 1, 8'hA1);
    add(0, 0, 1, 0, 0, 8'hB2, 2, 0, 0, 1, 8'hA1);
    add(0, 0, 1, 0, 0, 8'hC3, 3, 0, 0, 1, 8'hA1);
    add(0, 0, 1, 0, 0, 8'hD4, 4, 0, 0, 1, 8'hA1);
    // Push into full queue is dropped, then drain in order.
    add(0, 0, 1, 0, 0, 8'hEE, 4, 1, 0, 1, 8'hA1);
    add(0, 0, 0, 1, 0, 8'h00, 3, 1, 0, 1, 8'hB2);
    add(0, 0, 0, 1, 0, 8'h00, 2, 1, 0, 1, 8'hC3);
    add(0, 0, 0, 1, 0, 8'h00, 1, 1, 0, 1, 8'hD4);
    add(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    // Push+pop on empty: push taken, pop rejected, underflow set.
    add(0, 0, 1, 1, 0, 8'h55, 1, 1, 1, 1, 8'h55);
    add(0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 1, 8'h55);
    // Hold two entries and stream six push+pop pairs across the wrap.
    add(0, 0, 1, 0, 0, 8'h20, 2, 0, 0, 1, 8'h55);
    add(0, 0, 1, 1, 0, 8'h10, 2, 0, 0, 1, 8'h20);
    add(0, 0, 1, 1, 0, 8'h11, 2, 0, 0, 1, 8'h10);
    add(0, 0, 1, 1, 0, 8'h12, 2, 0, 0, 1, 8'h11);
    add(0, 0, 1, 1, 0, 8'h13, 2, 0, 0, 1, 8'h12);
    add(0, 0, 1, 1, 0, 8'h14, 2, 0, 0, 1, 8'h13);
    add(0, 0, 1, 1, 0, 8'h15, 2, 0, 0, 1, 8'h14);
    // Flush with push at count 3: empties, no write, flags untouched.
    add(0, 0, 1, 0, 0, 8'h16, 3, 0, 0, 1, 8'h14);
    add(0, 1, 1, 0, 0, 8'h99, 0, 0, 0, 0, 8'h00);
    // Repeat the flush with underflow already set to see it survive.
    add(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00);
    add(0, 0, 1, 0, 0, 8'h31, 1, 0, 1, 1, 8'h31);
    add(0, 0, 1, 0, 0, 8'h32, 2, 0, 1, 1, 8'h31);
    add(0, 0, 1, 0, 0, 8'h33, 3, 0, 1, 1, 8'h31);
    add(0, 1, 1, 0, 0, 8'h34, 0, 0, 1, 0, 8'h00);
    add(0, 0, 1, 0, 0, 8'h35, 1, 0, 1, 1, 8'h35);
    // Reset in mid-traffic overrides push+pop and clears the flags.
    add(0, 0, 1, 0, 0, 8'h36, 2, 0, 1, 1, 8'h35);
    add(1, 0, 1, 1, 0, 8'h40, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 0, 0, 8'h77, 1, 0, 0, 1, 8'h77);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].unf,
                  vecs[i].chk, vecs[i].dout);
    end

    // Corner: fill to full, then push+pop+clr_err at full. Pop is taken,
    // push dropped, and the fresh overflow beats the clear.
    drive(0, 0, 1, 0, 0, 8'h78);
    drive(0, 0, 1, 0, 0, 8'h79);
    drive(0, 0, 1, 0, 0, 8'h7A);
    check_state("fill", 4, 0, 0, 1, 8'h77);
    drive(0, 0, 1, 1, 1, 8'hF0);
    check_state("full_pushpop_clr", 3, 1, 0, 1, 8'h78);
    // Clear with no new error does clear.
    drive(0, 0, 0, 0, 1, 8'h00);
    check_state("clr_only", 3, 0, 0, 1, 8'h78);
    // Underflow set while clr_err is high: set wins again.
    drive(0, 1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 1, 8'h00);
    check_state("empty_pop_clr", 0, 0, 1, 0, 8'h00);

    // Random traffic against the queue model, starting from a reset.
    drive(1, 0, 0, 0, 0, 8'h00);
    model_step(1, 0, 0, 0, 0, 8'h00);
    for (int n = 0; n < 2000; n++) begin
      logic r, f, pu, po, c;
      logic [7:0] d;
      r  = ($urandom_range(0, 63) == 0);
      f  = ($urandom_range(0, 15) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      drive(r, f, pu, po, c, d);
      model_step(r, f, pu, po, c, d);
      check_state($sformatf("rnd%0d", n), mq.size(), m_ovf, m_unf,
                  mq.size() != 0, (mq.size() != 0) ? mq[0] : 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
